buffer_array: RTL and testbench
===============================

// Module: buffer_array
// PURPOSE
// - Array of IDIM independent output registers, one per input lane.
// - Each lane either buffers its input or accumulates it, as set by one shared control.
// - Accumulate mode counts stochastic bitstream 1s (IWID=1) into OWID-bit binary words.
// - Sits between the stochastic-computing datapath and downstream binary logic of uBrain.
// PARAMETERS
// - IDIM  4   number of lanes (input and output array depth)
// - IWID  1   width of each input lane, bits (1 = raw bitstream)
// - OWID  32  width of each output register, bits; must be >= IWID
// PORTS
// - clk      input   1                  clock; all state changes on rising edge
// - rst_n    input   1                  reset; synchronous, active-high (despite _n suffix)
// - iAccSel  input   1                  mode: 0 = buffer, 1 = accumulate; shared by all lanes
// - iClear   input   1                  synchronous clear of all lanes; active-high
// - iData    input   IWID x [IDIM]      unpacked array of lane inputs, unsigned
// - oData    output  OWID x [IDIM]      unpacked array of lane registers, unsigned
// BEHAVIOUR
// - Every oData[i] is a register; no combinational path from iData to oData.
// - Priority per rising clk, highest first:
//   - rst_n=1: all oData[i] <= 0.
//   - else iClear=1: all oData[i] <= 0.
//   - else iAccSel=0: oData[i] <= zero-extend(iData[i]) (buffer).
//   - else iAccSel=1: oData[i] <= oData[i] + zero-extend(iData[i]) (accumulate).
// - Reset value of every oData[i] is 0.
// - Latency is 1 cycle: an input sampled at edge k is visible after edge k.
// - Accumulate is unsigned modulo 2^OWID; overflow wraps silently, no flag.
// - Mode switch buffer->accumulate: accumulation starts from the value last buffered, not from 0.
// - Mode switch accumulate->buffer: next edge overwrites the sum with iData.
// - iClear and iAccSel may change on any cycle.
// - iClear=1 during accumulate zeroes the sum on that edge; the input on that edge is discarded.
// - Lanes are fully independent apart from the shared controls; no cross-lane arithmetic.
// - Reset asserted mid-operation zeroes all lanes at the next edge regardless of other inputs.
// TESTING (10 ns clock)
// - Reset: hold rst_n=1 for 10 cycles with iData all 1 -> every oData = 0.
// - Buffer mode: rst_n=0, iAccSel=0, iData={1,1,1,1} for 20 cycles
//   -> every oData = 1 after the first edge and stays 1.
// - Accumulate mode: from oData=1, set iAccSel=1, iData all 1 for 10 cycles
//   -> oData = 2,3,...,11 on successive edges.
// - Clear: iClear=1 for 1 cycle in either mode -> all oData = 0.
//   - Then in accumulate with iData=1 for N cycles -> oData = N.
// - Per-lane and wrap: iData={1,0,1,0} accumulating -> lanes 0,2 count, lanes 1,3 hold 0.
//   - With OWID=4, 17 accumulate cycles of 1 from 0 -> oData = 1 (wrapped).
// - Reset/clear priority: rst_n=1 with iClear=0 and iAccSel=1 mid-accumulation -> all 0 next edge.
//   - iClear=1 with iAccSel=1 and iData=1 -> 0, not 1.

Source files
------------

// File: rtl/buffer_array.sv
// Array of independent per-lane output registers. Each lane buffers or accumulates its input,
// selected by one shared mode control, with a shared synchronous clear.
module buffer_array #(
    parameter int unsigned IDIM = 4,
    parameter int unsigned IWID = 1,
    parameter int unsigned OWID = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iAccSel,
    input  logic            iClear,
    input  logic [IWID-1:0] iData [IDIM],
    output logic [OWID-1:0] oData [IDIM]
);

    logic [OWID-1:0] data_q [IDIM];
    logic [OWID-1:0] data_d [IDIM];

    // Per-lane next value: clear beats mode; accumulate wraps modulo 2^OWID.
    always_comb begin
        for (int unsigned i = 0; i < IDIM; i++) begin
            data_d[i] = data_q[i];
            if (iClear) begin
                data_d[i] = '0;
            end else if (iAccSel) begin
                data_d[i] = data_q[i] + OWID'(iData[i]);
            end else begin
                data_d[i] = OWID'(iData[i]);
            end
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < IDIM; i++) begin
            if (rst_n) begin
                data_q[i] <= '0;
            end else begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign oData = data_q;

endmodule

// File: tb/tb_buffer_array.sv
// Directed self-checking bench for buffer_array: a 32-bit instance for the main behaviour and
// a 4-bit instance sharing the same stimulus for the wrap-around case.
module tb_buffer_array;

    localparam int unsigned IDIM = 4;
    localparam int unsigned IWID = 1;
    localparam int unsigned OWID = 32;
    localparam int unsigned OWID_S = 4;

    logic            clk;
    logic            rst_n;
    logic            iAccSel;
    logic            iClear;
    logic [IWID-1:0] iData [IDIM];
    logic [OWID-1:0]   oData   [IDIM];
    logic [OWID_S-1:0] oData_s [IDIM];

    int checks;
    int failures;

    buffer_array #(.IDIM(IDIM), .IWID(IWID), .OWID(OWID)) dut (
        .clk(clk), .rst_n(rst_n), .iAccSel(iAccSel), .iClear(iClear),
        .iData(iData), .oData(oData)
    );

    buffer_array #(.IDIM(IDIM), .IWID(IWID), .OWID(OWID_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .iAccSel(iAccSel), .iClear(iClear),
        .iData(iData), .oData(oData_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge; outputs are sampled and inputs changed 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [IDIM-1:0] v);
        for (int i = 0; i < int'(IDIM); i++) iData[i] = v[i];
    endtask

    task automatic test_reset();
        rst_n = 1'b1; iClear = 1'b0; iAccSel = 1'b1; set_data(4'b1111);
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < int'(IDIM); i++) begin
                checks++;
                if (oData[i] !== 32'd0) begin
                    failures++;
                    $display("FAIL reset cyc%0d lane%0d got=%0d exp=0", c, i, oData[i]);
                end
            end
        end
    endtask

    task automatic test_buffer();
        rst_n = 1'b0; iClear = 1'b0; iAccSel = 1'b0; set_data(4'b1111);
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int i = 0; i < int'(IDIM); i++) begin
                checks++;
                if (oData[i] !== 32'd1) begin
                    failures++;
                    $display("FAIL buffer cyc%0d lane%0d got=%0d exp=1", c, i, oData[i]);
                end
            end
        end
    endtask

    // Continues from buffered value 1, so the sum starts at 2.
    task automatic test_accumulate();
        iAccSel = 1'b1; set_data(4'b1111);
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < int'(IDIM); i++) begin
                checks++;
                if (oData[i] !== 32'(c + 2)) begin
                    failures++;
                    $display("FAIL accumulate cyc%0d lane%0d got=%0d exp=%0d", c, i, oData[i], c + 2);
                end
            end
        end
    endtask

    task automatic test_clear();
        iAccSel = 1'b1; iClear = 1'b1; set_data(4'b1111);
        tick();
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== 32'd0) begin
                failures++;
                $display("FAIL clear_acc lane%0d got=%0d exp=0", i, oData[i]);
            end
        end
        iClear = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            for (int i = 0; i < int'(IDIM); i++) begin
                checks++;
                if (oData[i] !== 32'(c)) begin
                    failures++;
                    $display("FAIL clear_count n%0d lane%0d got=%0d exp=%0d", c, i, oData[i], c);
                end
            end
        end
        iAccSel = 1'b0; iClear = 1'b1;
        tick();
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== 32'd0) begin
                failures++;
                $display("FAIL clear_buf lane%0d got=%0d exp=0", i, oData[i]);
            end
        end
        iClear = 1'b0;
    endtask

    task automatic test_per_lane();
        iClear = 1'b1; tick(); iClear = 1'b0;
        iAccSel = 1'b1; set_data(4'b0101);
        for (int c = 1; c <= 6; c++) begin
            tick();
            for (int i = 0; i < int'(IDIM); i++) begin
                checks++;
                if (oData[i] !== ((i % 2 == 0) ? 32'(c) : 32'd0)) begin
                    failures++;
                    $display("FAIL per_lane n%0d lane%0d got=%0d exp=%0d", c, i, oData[i],
                             (i % 2 == 0) ? c : 0);
                end
            end
        end
    endtask

    task automatic test_wrap();
        iClear = 1'b1; tick(); iClear = 1'b0;
        iAccSel = 1'b1; set_data(4'b1111);
        for (int c = 1; c <= 17; c++) begin
            tick();
            for (int i = 0; i < int'(IDIM); i++) begin
                checks++;
                if (oData_s[i] !== 4'(c % 16)) begin
                    failures++;
                    $display("FAIL wrap4 n%0d lane%0d got=%0d exp=%0d", c, i, oData_s[i], c % 16);
                end
            end
        end
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== 32'd17) begin
                failures++;
                $display("FAIL nowrap32 lane%0d got=%0d exp=17", i, oData[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        // Buffer 1 on lanes 0,2 and 0 on lanes 1,3, then accumulate all-ones from there.
        iAccSel = 1'b0; set_data(4'b0101);
        tick();
        iAccSel = 1'b1; set_data(4'b1111);
        tick();
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== ((i % 2 == 0) ? 32'd2 : 32'd1)) begin
                failures++;
                $display("FAIL buf_to_acc lane%0d got=%0d exp=%0d", i, oData[i], (i % 2 == 0) ? 2 : 1);
            end
        end
        tick(); tick();
        iAccSel = 1'b0; set_data(4'b0110);
        tick();
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== ((i == 1 || i == 2) ? 32'd1 : 32'd0)) begin
                failures++;
                $display("FAIL acc_to_buf lane%0d got=%0d exp=%0d", i, oData[i], (i == 1 || i == 2) ? 1 : 0);
            end
        end
    endtask

    // Back-to-back priority: reset over accumulate, then clear over accumulate.
    task automatic test_back_to_back();
        iClear = 1'b0; iAccSel = 1'b1; set_data(4'b1111);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== 32'd0) begin
                failures++;
                $display("FAIL rst_mid_acc lane%0d got=%0d exp=0", i, oData[i]);
            end
        end
        rst_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== 32'd2) begin
                failures++;
                $display("FAIL post_rst_acc lane%0d got=%0d exp=2", i, oData[i]);
            end
        end
        iClear = 1'b1;
        tick();
        for (int i = 0; i < int'(IDIM); i++) begin
            checks++;
            if (oData[i] !== 32'd0) begin
                failures++;
                $display("FAIL clear_over_acc lane%0d got=%0d exp=0", i, oData[i]);
            end
        end
        iClear = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1; iClear = 1'b0; iAccSel = 1'b0; set_data(4'b0000);
        #1;
        test_reset();
        test_buffer();
        test_accumulate();
        test_clear();
        test_per_lane();
        test_wrap();
        test_mode_switch();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
